// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the display fetcher and the CPU, with a display-streak starvation guard
module vram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_DISP_STREAK = 4
) (
  input  logic                  CLK_50MHz,
  input  logic                  RESET,
  input  logic                  DISP_REQ,
  input  logic [ADDR_WIDTH-1:0] DISP_ADDR,
  output logic                  DISP_ACK,
  output logic [DATA_WIDTH-1:0] DISP_DATA,
  input  logic                  CPU_REQ,
  input  logic                  CPU_WE,
  input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
  input  logic [DATA_WIDTH-1:0] CPU_WDATA,
  output logic                  CPU_ACK,
  output logic [DATA_WIDTH-1:0] CPU_RDATA,
  output logic                  MEM_EN,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic                  BUSY
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(MAX_DISP_STREAK + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic owner_cpu_q, owner_cpu_d;
  logic wr_q, wr_d;
  logic mem_en_q, mem_en_d;
  logic mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic disp_ack_q, disp_ack_d;
  logic cpu_ack_q, cpu_ack_d;
  logic busy_q, busy_d;
  logic wait_last, grant, pick_cpu, cap;
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      streak_q    <= '0;
      owner_cpu_q <= 1'b0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      disp_data_q <= '0;
      cpu_rdata_q <= '0;
      disp_ack_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      streak_q    <= streak_d;
      owner_cpu_q <= owner_cpu_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      disp_data_q <= disp_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      disp_ack_q  <= disp_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      busy_q      <= busy_d;
    end
  end
  always_comb begin
    wait_last  = wait_cnt_q == CW'(MEM_LATENCY - 1);
    state_d    = state_q == IDLE  ? ((DISP_REQ | CPU_REQ) ? ISSUE : IDLE) :
                 state_q == ISSUE ? WAIT :
                 state_q == WAIT  ? (wait_last ? DONE : WAIT) : IDLE;
    wait_cnt_d = state_q == WAIT ? wait_cnt_q + CW'(1) : '0;
  end
  always_comb begin
    grant       = state_q == IDLE & (DISP_REQ | CPU_REQ);
    pick_cpu    = CPU_REQ & (~DISP_REQ | streak_q == SW'(MAX_DISP_STREAK));
    streak_d    = !grant ? streak_q :
                  (pick_cpu | ~CPU_REQ) ? '0 :
                  streak_q == SW'(MAX_DISP_STREAK) ? streak_q : streak_q + SW'(1);
    owner_cpu_d = grant ? pick_cpu : owner_cpu_q;
    wr_d        = grant ? pick_cpu & CPU_WE : wr_q;
    mem_en_d    = grant;
    mem_we_d    = grant & pick_cpu & CPU_WE;
    mem_addr_d  = grant ? (pick_cpu ? CPU_ADDR : DISP_ADDR) : mem_addr_q;
    mem_wdata_d = (grant & pick_cpu) ? CPU_WDATA : mem_wdata_q;
    cap         = state_q == WAIT & wait_last;
    disp_data_d = (cap & ~owner_cpu_q) ? MEM_RDATA : disp_data_q;
    cpu_rdata_d = (cap & owner_cpu_q & ~wr_q) ? MEM_RDATA : cpu_rdata_q;
    disp_ack_d  = cap & ~owner_cpu_q;
    cpu_ack_d   = cap & owner_cpu_q;
    busy_d      = state_d != IDLE;
  end
  assign DISP_ACK  = disp_ack_q;
  assign DISP_DATA = disp_data_q;
  assign CPU_ACK   = cpu_ack_q;
  assign CPU_RDATA = cpu_rdata_q;
  assign MEM_EN    = mem_en_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign BUSY      = busy_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: vector table, corner sequences and a randomized transaction-level model for vram_arbiter
module tb_vram_arbiter;
  localparam int L = 2;
  localparam int M = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic d_req, d_ack, c_req, c_we, c_ack, m_en, m_we, busy;
  logic [14:0] d_addr, c_addr, m_addr;
  logic [7:0] d_data, c_wdata, c_rdata, m_wdata, m_rdata;
  logic c_req1, c_we1, c_ack1, d_ack1, m_en1, m_we1, busy1;
  logic [14:0] c_addr1, m_addr1;
  logic [7:0] c_wdata1, c_rdata1, d_data1, m_wdata1, m_rdata1;
  vram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .MEM_LATENCY(L), .MAX_DISP_STREAK(M)) dut (
    .CLK_50MHz(clk), .RESET(rst),
    .DISP_REQ(d_req), .DISP_ADDR(d_addr), .DISP_ACK(d_ack), .DISP_DATA(d_data),
    .CPU_REQ(c_req), .CPU_WE(c_we), .CPU_ADDR(c_addr), .CPU_WDATA(c_wdata),
    .CPU_ACK(c_ack), .CPU_RDATA(c_rdata),
    .MEM_EN(m_en), .MEM_WE(m_we), .MEM_ADDR(m_addr), .MEM_WDATA(m_wdata),
    .MEM_RDATA(m_rdata), .BUSY(busy)
  );
  vram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .MEM_LATENCY(1), .MAX_DISP_STREAK(M)) dut1 (
    .CLK_50MHz(clk), .RESET(rst),
    .DISP_REQ(1'b0), .DISP_ADDR(15'h0), .DISP_ACK(d_ack1), .DISP_DATA(d_data1),
    .CPU_REQ(c_req1), .CPU_WE(c_we1), .CPU_ADDR(c_addr1), .CPU_WDATA(c_wdata1),
    .CPU_ACK(c_ack1), .CPU_RDATA(c_rdata1),
    .MEM_EN(m_en1), .MEM_WE(m_we1), .MEM_ADDR(m_addr1), .MEM_WDATA(m_wdata1),
    .MEM_RDATA(m_rdata1), .BUSY(busy1)
  );
  function automatic logic [7:0] h(input logic [14:0] a);
    return a == 15'h0123 ? 8'h5A : a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
  endfunction
  // RAM model: read data is valid only in the single cycle exactly MEM_LATENCY cycles after the strobe
  logic [14:0] pa0, pa1;
  int pc0, pc1;
  always @(posedge clk) begin
    if (rst) begin
      pc0 <= 0;
      pc1 <= 0;
    end else begin
      if (m_en) begin pa0 <= m_addr; pc0 <= L; end
      else if (pc0 != 0) pc0 <= pc0 - 1;
      if (m_en1) begin pa1 <= m_addr1; pc1 <= 1; end
      else if (pc1 != 0) pc1 <= pc1 - 1;
    end
  end
  assign m_rdata  = (pc0 == 1) ? h(pa0) : 8'hEE;
  assign m_rdata1 = (pc1 == 1) ? h(pa1) : 8'hEE;
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {
    bit dr; bit cr; bit we;
    logic [14:0] da; logic [14:0] ca; logic [7:0] wd;
    bit ecpu; logic [14:0] eaddr; bit ewe; logic [7:0] edata;
  } vec_t;
  vec_t vecs[6];
  int ack_k, n_ack, en_n, seen, last, n;
  bit ack_cpu;
  int nf, gc, streak;
  bit gcpu, gwe, dact, cact;
  logic [14:0] gaddr;
  logic [7:0] gwd, edd, ecr;
  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 15'h0123, 15'h0000, 8'h00, 1'b0, 15'h0123, 1'b0, 8'h5A};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 15'h0000, 15'h7FFF, 8'hA5, 1'b1, 15'h7FFF, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 15'h0200, 15'h0300, 8'h00, 1'b0, 15'h0200, 1'b0, h(15'h0200)};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 15'h0000, 15'h0042, 8'h00, 1'b1, 15'h0042, 1'b0, h(15'h0042)};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 15'h1234, 15'h4321, 8'h3C, 1'b0, 15'h1234, 1'b0, h(15'h1234)};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 15'h0000, 15'h0000, 8'h00, 1'b0, 15'h0000, 1'b0, h(15'h0000)};
    rst = 1; d_req = 0; c_req = 0; c_we = 0; d_addr = 0; c_addr = 0; c_wdata = 0;
    c_req1 = 0; c_we1 = 0; c_addr1 = 0; c_wdata1 = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rst = 1;
      @(negedge clk);
      rst = 0;
      d_req = vecs[i].dr; c_req = vecs[i].cr; c_we = vecs[i].we;
      d_addr = vecs[i].da; c_addr = vecs[i].ca; c_wdata = vecs[i].wd;
      ack_k = -1; n_ack = 0; en_n = 0; ack_cpu = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (m_en) begin
          en_n++;
          chk("vec_en_cycle", k, 1);
          chk("vec_mem_addr", m_addr, vecs[i].eaddr);
          chk("vec_mem_we", m_we, vecs[i].ewe);
          if (vecs[i].ewe) chk("vec_mem_wdata", m_wdata, vecs[i].wd);
        end
        if (d_ack | c_ack) begin
          n_ack++; ack_k = k; ack_cpu = c_ack;
          d_req = 0; c_req = 0;
        end
      end
      chk("vec_ack_latency", ack_k, L + 2);
      chk("vec_ack_count", n_ack, 1);
      chk("vec_owner", ack_cpu, vecs[i].ecpu);
      chk("vec_en_count", en_n, 1);
      chk("vec_data", vecs[i].ecpu ? c_rdata : d_data, vecs[i].edata);
    end
    // reset held three cycles in the middle of a display read
    rst = 1; @(negedge clk); rst = 0;
    d_req = 1; d_addr = 15'h0456;
    repeat (2) @(negedge clk);
    chk("rst_busy_before", busy, 1);
    rst = 1; n = 0;
    repeat (3) begin @(negedge clk); n += int'(d_ack | c_ack); end
    rst = 0; d_req = 0;
    @(negedge clk);
    chk("rst_out_zero", {d_ack, c_ack, m_en, m_we, busy, d_data, c_rdata, m_addr, m_wdata}, 0);
    repeat (6) begin @(negedge clk); n += int'(d_ack | c_ack); end
    chk("rst_no_ack", n, 0);
    // both requesters held high continuously
    rst = 1; @(negedge clk); rst = 0;
    d_req = 1; c_req = 1; c_we = 0; d_addr = 15'h0100; c_addr = 15'h0200;
    seen = 0;
    for (int k = 0; k < 200 && seen < 10; k++) begin
      @(negedge clk);
      if (d_ack | c_ack) begin
        chk("arb_order", c_ack, seen % 5 == 4);
        if (d_ack) begin chk("arb_disp_data", d_data, h(d_addr)); d_addr++; end
        else begin chk("arb_cpu_data", c_rdata, h(c_addr)); c_addr++; end
        seen++;
      end
    end
    chk("arb_grant_count", seen, 10);
    d_req = 0; c_req = 0;
    // back-to-back display reads with REQ held
    rst = 1; @(negedge clk); rst = 0;
    d_req = 1; d_addr = 15'h0300; seen = 0; last = -1;
    for (int k = 0; k < 60 && seen < 4; k++) begin
      @(negedge clk);
      if (d_ack) begin
        if (last >= 0) chk("b2b_gap", k - last, L + 3);
        chk("b2b_data", d_data, h(d_addr));
        last = k; d_addr++; seen++;
      end
    end
    chk("b2b_count", seen, 4);
    d_req = 0;
    // CPU read on the single-cycle-latency build
    @(negedge clk);
    c_req1 = 1; c_we1 = 0; c_addr1 = 15'h0ABC;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("l1_busy", busy1, k <= 3);
      chk("l1_en", m_en1, k == 1);
      chk("l1_ack", c_ack1, k == 3);
      if (c_ack1) begin chk("l1_rdata", c_rdata1, h(15'h0ABC)); c_req1 = 0; end
    end
    // randomized traffic against a transaction-timed model
    rst = 1; d_req = 0; c_req = 0; @(negedge clk); rst = 0;
    nf = 0; gc = -1000; streak = 0; gcpu = 0; gwe = 0; gaddr = 0; gwd = 0;
    edd = 0; ecr = 0; dact = 0; cact = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == gc + L + 2) begin
        if (!gcpu) edd = h(gaddr);
        else if (!gwe) ecr = h(gaddr);
      end
      chk("rnd_en", m_en, c == gc + 1);
      chk("rnd_busy", busy, c >= gc + 1 && c <= gc + L + 2);
      chk("rnd_disp_ack", d_ack, c == gc + L + 2 && !gcpu);
      chk("rnd_cpu_ack", c_ack, c == gc + L + 2 && gcpu);
      chk("rnd_disp_data", d_data, edd);
      chk("rnd_cpu_rdata", c_rdata, ecr);
      if (c == gc + 1) begin
        chk("rnd_mem_addr", m_addr, gaddr);
        chk("rnd_mem_we", m_we, gwe);
        if (gwe) chk("rnd_mem_wdata", m_wdata, gwd);
      end else chk("rnd_we_idle", m_we, 0);
      if (d_ack) dact = 0;
      if (c_ack) cact = 0;
      if (!dact && $urandom_range(0, 2) == 0) begin dact = 1; d_addr = 15'($urandom); end
      if (!cact && $urandom_range(0, 3) == 0) begin
        cact = 1; c_addr = 15'($urandom); c_we = 1'($urandom); c_wdata = 8'($urandom);
      end
      d_req = dact; c_req = cact;
      if (c >= nf && (d_req || c_req)) begin
        gcpu = c_req && (!d_req || streak == M);
        gwe = gcpu && c_we;
        gaddr = gcpu ? c_addr : d_addr;
        gwd = c_wdata;
        streak = (gcpu || !c_req) ? 0 : (streak < M ? streak + 1 : M);
        gc = c;
        nf = c + L + 3;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
